// File: rtl/dense_layer_mac.sv
// dense_layer_mac: streaming dense-layer MAC, one pixel per cycle in, one neuron sum per beat out
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   x_tdata/tvalid/tready  pixel stream in (low PIXEL_W bits used, unsigned)
//   w_addr, w_rdata     synchronous weight ROM: row address out, row of signed lanes back one cycle later
//   y_tdata/tvalid/tready/tlast  neuron sums out, sign-extended, tlast on the final neuron
//   busy                high while flushing or streaming sums out
module dense_layer_mac #(
   parameter int NUM_INPUTS  = 784,
   parameter int NUM_NEURONS = 10,
   parameter int PIXEL_W     = 8,
   parameter int WEIGHT_W    = 8,
   parameter int ACC_W       = 32,
   parameter int ADDR_W      = 10
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [31:0]                     x_tdata,
   input  logic                            x_tvalid,
   output logic                            x_tready,
   output logic [ADDR_W-1:0]               w_addr,
   input  logic [NUM_NEURONS*WEIGHT_W-1:0] w_rdata,
   output logic [31:0]                     y_tdata,
   output logic                            y_tvalid,
   input  logic                            y_tready,
   output logic                            y_tlast,
   output logic                            busy
);
   localparam int PW = PIXEL_W + WEIGHT_W + 1;
   localparam int OW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;

   typedef enum logic [1:0] {S_ACCUM, S_FLUSH, S_OUT} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    in_idx_q, in_idx_d;
   logic [OW-1:0]        out_idx_q, out_idx_d;
   logic                 pv_q, pv_d;
   logic [PIXEL_W-1:0]   pix_q, pix_d;
   logic [ACC_W-1:0]     acc_q [NUM_NEURONS];
   logic [ACC_W-1:0]     acc_d [NUM_NEURONS];
   logic signed [PW-1:0] prod [NUM_NEURONS];
   logic                 x_hs, y_hs, last_px, last_beat;
   logic                 unused_bits;

   assign unused_bits = ^x_tdata[31:PIXEL_W];

   // tready is forced low while reset is held, even though the state already reads S_ACCUM
   assign x_tready  = ~areset & (state_q == S_ACCUM);
   assign x_hs      = x_tready & x_tvalid;
   assign last_px   = in_idx_q == ADDR_W'(NUM_INPUTS - 1);
   assign last_beat = out_idx_q == OW'(NUM_NEURONS - 1);
   assign y_tvalid  = state_q == S_OUT;
   assign y_hs      = y_tvalid & y_tready;
   assign y_tlast   = y_tvalid & last_beat;
   assign y_tdata   = y_tvalid ? 32'($signed(acc_q[out_idx_q])) : '0;
   assign busy      = state_q != S_ACCUM;
   // in_idx is held at the accepted pixel's index during the accept cycle, so the ROM row lines up with pix_q
   assign w_addr    = in_idx_q;

   // zero-extended pixel times sign-extended weight, both widened to the full product width
   always_comb begin
      for (int k = 0; k < NUM_NEURONS; k++)
         prod[k] = $signed({{(WEIGHT_W + 1){1'b0}}, pix_q}) *
                   $signed({{(PIXEL_W + 1){w_rdata[k*WEIGHT_W + WEIGHT_W - 1]}}, w_rdata[k*WEIGHT_W +: WEIGHT_W]});
   end

   always_comb begin
      state_d   = state_q;
      out_idx_d = out_idx_q;
      in_idx_d  = x_hs ? (last_px ? '0 : in_idx_q + ADDR_W'(1)) : in_idx_q;
      pix_d     = x_hs ? x_tdata[PIXEL_W-1:0] : pix_q;
      pv_d      = x_hs;
      for (int k = 0; k < NUM_NEURONS; k++)
         acc_d[k] = (y_hs & last_beat) ? '0 : pv_q ? acc_q[k] + ACC_W'(prod[k]) : acc_q[k];
      case (state_q)
         S_ACCUM: state_d = (x_hs & last_px) ? S_FLUSH : S_ACCUM;
         S_FLUSH: begin
            state_d   = S_OUT;
            out_idx_d = '0;
         end
         S_OUT: begin
            state_d   = (y_hs & last_beat) ? S_ACCUM : S_OUT;
            out_idx_d = y_hs ? (last_beat ? '0 : out_idx_q + OW'(1)) : out_idx_q;
         end
         default: state_d = S_ACCUM;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= S_ACCUM;
         in_idx_q  <= '0;
         out_idx_q <= '0;
         pv_q      <= 1'b0;
         pix_q     <= '0;
         for (int k = 0; k < NUM_NEURONS; k++)
            acc_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         in_idx_q  <= in_idx_d;
         out_idx_q <= out_idx_d;
         pv_q      <= pv_d;
         pix_q     <= pix_d;
         for (int k = 0; k < NUM_NEURONS; k++)
            acc_q[k] <= acc_d[k];
      end
   end
endmodule

// File: tb/tb_dense_layer_mac.sv
// tb_dense_layer_mac: table-driven and randomized frames checked against an arithmetic dot-product model
module tb_dense_layer_mac;
   localparam int NI = 784;
   localparam int NN = 10;

   typedef struct {
      int          pm;
      int          wm;
      logic [23:0] hi;
      bit          has_exp;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] er;
      bit          gaps;
      bit          stall;
   } vec_t;

   logic        aclk = 1'b0;
   logic        areset = 1'b0;
   logic [31:0] x_tdata = '0;
   logic        x_tvalid = 1'b0;
   logic        x_tready;
   logic [9:0]  w_addr;
   logic [79:0] w_rdata = '0;
   logic [31:0] y_tdata;
   logic        y_tvalid;
   logic        y_tready = 1'b0;
   logic        y_tlast;
   logic        busy;

   logic [31:0] xw [2*NI];
   logic [79:0] wmem [NI];

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          acc_cyc [$];
   logic [9:0]  acc_addr [$];
   logic [32:0] beats [$];
   int          y_cyc [$];
   int          xr_rise = -1;
   bit          chk_out = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_d = '0;
   logic        prev_l = 1'b0;
   logic        prev_xr = 1'b0;

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;
   always @(posedge aclk) w_rdata <= wmem[w_addr];

   dense_layer_mac dut (
      .aclk(aclk), .areset(areset),
      .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
      .w_addr(w_addr), .w_rdata(w_rdata),
      .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tready(y_tready), .y_tlast(y_tlast),
      .busy(busy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // pm: 0 ramp, 1 all 0xFF, 2 all zero, 3 random; wm: 0 lane0=+1 lane1=-1, 1 all -128, 2 random
   task automatic fill(input int pm, input int wm, input logic [23:0] hi, input int f);
      for (int i = 0; i < NI; i++) begin
         logic [7:0] p;
         p = pm == 0 ? 8'(i % 256) : pm == 1 ? 8'hFF : pm == 2 ? 8'h00 : 8'($urandom);
         xw[f*NI + i] = {pm == 3 ? 24'($urandom) : hi, p};
         if (f == 0)
            for (int k = 0; k < NN; k++)
               wmem[i][k*8 +: 8] = wm == 0 ? (k == 0 ? 8'h01 : k == 1 ? 8'hFF : 8'h00) :
                                   wm == 1 ? 8'h80 : 8'($urandom);
      end
   endtask

   function automatic int model(input int f, input int k);
      int s = 0;
      for (int i = 0; i < NI; i++) begin
         byte w;
         w = byte'(wmem[i][k*8 +: 8]);
         s += int'(xw[f*NI + i][7:0]) * int'(w);
      end
      return s;
   endfunction

   // Observes handshakes at the negedge; each one completes on the following rising edge (cyc + 1)
   always @(negedge aclk) begin
      if (x_tvalid && x_tready) begin
         acc_cyc.push_back(cyc + 1);
         acc_addr.push_back(w_addr);
      end
      if (y_tvalid && y_tready) begin
         beats.push_back({y_tlast, y_tdata});
         y_cyc.push_back(cyc + 1);
      end
      if (prev_stall) begin
         check("stall_data", y_tdata, prev_d);
         check("stall_last", 32'(y_tlast), 32'(prev_l));
      end
      if (chk_out && y_tvalid) begin
         check("xready_in_out", 32'(x_tready), 32'd0);
         check("busy_in_out", 32'(busy), 32'd1);
      end
      if (x_tready && !prev_xr) xr_rise <= cyc;
      prev_stall <= y_tvalid && !y_tready;
      prev_d     <= y_tdata;
      prev_l     <= y_tlast;
      prev_xr    <= x_tready;
   end

   task automatic run_frame(input int nf, input bit gaps, input bit stall);
      int seen = 0, cnt = 0, t = 0, errs = 0, i;
      acc_cyc.delete();
      acc_addr.delete();
      beats.delete();
      y_cyc.delete();
      chk_out  = stall;
      y_tready = !stall;
      while (beats.size() < nf*NN && t < 6000*nf) begin
         @(posedge aclk);
         #1;
         t++;
         i = acc_cyc.size();
         x_tvalid = i < nf*NI && (!gaps || $urandom_range(0, 2) != 0);
         x_tdata  = i < nf*NI ? xw[i] : '0;
         if (stall) begin
            if (beats.size() != seen) begin
               seen = beats.size();
               cnt  = 0;
            end
            y_tready = y_tvalid && cnt >= 5;
            if (y_tvalid && cnt < 5) cnt++;
         end
      end
      x_tvalid = 1'b0;
      chk_out  = 1'b0;
      @(negedge aclk);
      #1;
      y_tready = 1'b0;
      check("beat_count", beats.size(), nf*NN);
      check("accept_count", acc_cyc.size(), nf*NI);
      for (int f = 0; f < nf; f++)
         for (int k = 0; k < NN; k++)
            if (f*NN + k < beats.size()) begin
               check($sformatf("f%0d_sum%0d", f, k), beats[f*NN + k][31:0], model(f, k));
               check($sformatf("f%0d_last%0d", f, k), 32'(beats[f*NN + k][32]), 32'(k == NN - 1));
            end
      for (int j = 0; j < acc_addr.size(); j++)
         if (acc_addr[j] != 10'(j % NI)) errs++;
      check("waddr_seq_errors", errs, 0);
      if (!stall && beats.size() > 0 && acc_cyc.size() >= NI)
         check("latency_edges", y_cyc[0] - acc_cyc[NI-1], 2);
      if (nf > 1 && !gaps && acc_cyc.size() > NI)
         check("frame_period", acc_cyc[NI] - acc_cyc[0], NI + 1 + NN);
      if (y_cyc.size() > 0)
         check("xready_return", xr_rise, y_cyc[$]);
   endtask

   initial begin
      vec_t vt [7];
      int   t;
      vt[0] = '{0, 0, 24'h0,      1'b1, 32'h00017EF8, 32'hFFFE8108, 32'h0,        1'b0, 1'b0};
      vt[1] = '{1, 1, 24'hABCD12, 1'b1, 32'hFE798800, 32'hFE798800, 32'hFE798800, 1'b0, 1'b0};
      vt[2] = '{1, 1, 24'h0,      1'b1, 32'hFE798800, 32'hFE798800, 32'hFE798800, 1'b0, 1'b0};
      vt[3] = '{0, 0, 24'h0,      1'b1, 32'h00017EF8, 32'hFFFE8108, 32'h0,        1'b1, 1'b0};
      vt[4] = '{0, 0, 24'h0,      1'b1, 32'h00017EF8, 32'hFFFE8108, 32'h0,        1'b0, 1'b1};
      vt[5] = '{3, 2, 24'h0,      1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0};
      vt[6] = '{3, 2, 24'h0,      1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1};
      fill(0, 0, 24'h0, 0);
      areset = 1'b1;
      #12;
      check("rst_x_tready", 32'(x_tready), 32'd0);
      check("rst_y_tvalid", 32'(y_tvalid), 32'd0);
      check("rst_y_tlast", 32'(y_tlast), 32'd0);
      check("rst_y_tdata", y_tdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_w_addr", 32'(w_addr), 32'd0);
      @(negedge aclk);
      areset = 1'b0;
      #1;
      check("first_x_tready", 32'(x_tready), 32'd1);

      for (int v = 0; v < 7; v++) begin
         fill(vt[v].pm, vt[v].wm, vt[v].hi, 0);
         run_frame(1, vt[v].gaps, vt[v].stall);
         if (vt[v].has_exp)
            for (int k = 0; k < NN; k++)
               if (k < beats.size())
                  check($sformatf("vec%0d_beat%0d", v, k), beats[k][31:0],
                        k == 0 ? vt[v].e0 : k == 1 ? vt[v].e1 : vt[v].er);
      end

      // back-to-back: ramp then zero pixels with x_tvalid held high across the boundary
      fill(0, 0, 24'h0, 0);
      fill(2, 0, 24'h0, 1);
      run_frame(2, 1'b0, 1'b0);
      for (int k = 0; k < NN; k++)
         if (NN + k < beats.size()) check($sformatf("b2b_zero%0d", k), beats[NN + k][31:0], 32'd0);

      // reset after 400 accepted pixels, then a clean ramp frame
      fill(0, 0, 24'h0, 0);
      acc_cyc.delete();
      t = 0;
      while (acc_cyc.size() < 400 && t < 2000) begin
         @(posedge aclk);
         #1;
         t++;
         x_tvalid = 1'b1;
         x_tdata  = xw[acc_cyc.size()];
      end
      x_tvalid = 1'b0;
      check("pre_reset_accepts", acc_cyc.size(), 400);
      #2;
      areset = 1'b1;
      #1;
      check("mid_rst_x_tready", 32'(x_tready), 32'd0);
      check("mid_rst_y_tvalid", 32'(y_tvalid), 32'd0);
      check("mid_rst_y_tlast", 32'(y_tlast), 32'd0);
      check("mid_rst_y_tdata", y_tdata, 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_w_addr", 32'(w_addr), 32'd0);
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      #1;
      check("post_rst_x_tready", 32'(x_tready), 32'd1);
      run_frame(1, 1'b0, 1'b0);
      if (beats.size() > 1) begin
         check("post_rst_beat0", beats[0][31:0], 32'h00017EF8);
         check("post_rst_beat1", beats[1][31:0], 32'hFFFE8108);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
